// File: rtl/util_axis_capture_pkg.sv
// Shared definitions for the AXI-Stream capture block.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default beat width and buffer address width
//   state_t                                 : capture FSM state encoding
package util_axis_capture_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/util_sdpram.sv
// Inferred simple dual-port RAM, one write port and one registered read port.
//   clk             : clock
//   rst_n           : async active-low reset, clears only the read output register
//   we/waddr/wdata  : write port
//   rd_en/raddr     : read request; rdata updates one cycle later
//   rdata           : registered read data, holds when rd_en is low
// Read-first: a same-cycle read and write to one address returns the old word.
module util_sdpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Storage is deliberately left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[raddr];
  end

endmodule

// File: rtl/util_axis_capture.sv
// AXI-Stream sink capturing a bounded burst of beats into a buffer with readback.
//   aclk, rst_n                  : clock, async active-low reset
//   s_axis_data_tvalid/tready/tdata : stream input; tready high only while capturing
//   arm, capture_len             : start a capture of capture_len beats (0 = full depth)
//   busy, done                   : FSM status (CAPTURE / DONE)
//   captured_count               : beats written since the last accepted arm
//   rd_en, rd_addr               : readback request
//   rd_data, rd_valid            : readback data, valid one cycle after rd_en
//
// state      | meaning
// ST_IDLE    | after reset, waiting for arm
// ST_CAPTURE | accepting beats until captured_count reaches target
// ST_DONE    | burst complete, buffer holds the data until the next arm
module util_axis_capture
  import util_axis_capture_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] capture_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   captured_count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] target;
  logic [ADDR_WIDTH:0] count_inc;
  logic                beat_ok, arm_ok, last_beat;

  assign beat_ok   = s_axis_data_tvalid && (state == ST_CAPTURE);
  assign arm_ok    = arm && (state != ST_CAPTURE);
  assign count_inc = captured_count + ONE;
  assign last_beat = beat_ok && (count_inc == target);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (arm)       state_nxt = ST_CAPTURE;
      ST_CAPTURE:       if (last_beat) state_nxt = ST_DONE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // captured_count doubles as the write pointer: it never exceeds target,
  // which is at most the depth, so its low bits never wrap within a burst.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      captured_count <= '0;
      target         <= DEPTH;
    end else if (arm_ok) begin
      captured_count <= '0;
      target         <= (capture_len == '0) ? DEPTH : {1'b0, capture_len};
    end else if (beat_ok) begin
      captured_count <= count_inc;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  assign s_axis_data_tready = (state == ST_CAPTURE);
  assign busy               = (state == ST_CAPTURE);
  assign done               = (state == ST_DONE);

  util_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buf (
    .clk   (aclk),
    .rst_n (rst_n),
    .we    (beat_ok),
    .waddr (captured_count[ADDR_WIDTH-1:0]),
    .wdata (s_axis_data_tdata),
    .rd_en (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
